// File: rtl/router_src_arbiter.sv
// router_src_arbiter: round-robin scheduler that hands the router's single
// byte-wide input to one packet source at a time. Each granted packet is walked
// through header, payload and parity using the length carried in its header.
// Packets addressed to the nonexistent port 3 are drained without reaching the
// router.
module router_src_arbiter #(
   parameter int NUM_SRC = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_SRC-1:0]   src_valid,
   input  logic [8*NUM_SRC-1:0] src_data,
   output logic [NUM_SRC-1:0]   src_ready,
   input  logic                 busy,
   output logic [7:0]           datain,
   output logic                 packet_valid,
   output logic [NUM_SRC-1:0]   grant,
   output logic                 pkt_done,
   output logic                 hdr_err,
   output logic                 proto_err
);

   localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [NUM_SRC-1:0] ONE_OH = {{(NUM_SRC-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HDR     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_PARITY  = 3'd3,
      S_DROP    = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [5:0]         cnt_q, cnt_d;
   logic [IW-1:0]      last_grant_q, last_grant_d;
   logic [NUM_SRC-1:0] grant_q, grant_d;
   logic               drop_hdr_q, drop_hdr_d;
   logic               proto_err_q, proto_err_d;

   logic               rr_hit_s;
   logic [IW-1:0]      rr_idx_s;
   logic [IW-1:0]      cand_s;
   logic [NUM_SRC-1:0] rr_oh_s;
   logic [7:0]         rr_hdr_s;
   logic [7:0]         cur_byte_s;
   logic               cur_valid_s;
   logic               xfer_s;

   // Round-robin search starting just after the last granted source.
   always_comb begin
      rr_hit_s = 1'b0;
      rr_idx_s = {IW{1'b0}};
      cand_s   = {IW{1'b0}};
      for (int i = 1; i <= NUM_SRC; i++) begin
         cand_s = IW'((int'(last_grant_q) + i) % NUM_SRC);
         if (!rr_hit_s && src_valid[cand_s]) begin
            rr_hit_s = 1'b1;
            rr_idx_s = cand_s;
         end else begin
            rr_hit_s = rr_hit_s;
         end
      end
      rr_oh_s  = ONE_OH << rr_idx_s;
      rr_hdr_s = 8'h00;
      for (int i = 0; i < NUM_SRC; i++) begin
         rr_hdr_s = rr_hdr_s | (src_data[8*i +: 8] & {8{rr_oh_s[i]}});
      end
   end

   // Byte and valid of the currently granted source (grant is 0 when idle).
   always_comb begin
      cur_byte_s = 8'h00;
      for (int i = 0; i < NUM_SRC; i++) begin
         cur_byte_s = cur_byte_s | (src_data[8*i +: 8] & {8{grant_q[i]}});
      end
      cur_valid_s = |(src_valid & grant_q);
      xfer_s      = cur_valid_s && !busy;
   end

   // Packet walk: next-state, counter, grant bookkeeping and router-side outputs.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      drop_hdr_d   = drop_hdr_q;
      proto_err_d  = proto_err_q;
      src_ready    = {NUM_SRC{1'b0}};
      datain       = 8'h00;
      packet_valid = 1'b0;
      pkt_done     = 1'b0;
      hdr_err      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rr_hit_s) begin
               grant_d = rr_oh_s;
               cnt_d   = rr_hdr_s[7:2];
               if (rr_hdr_s[1:0] == 2'b11) begin
                  state_d    = S_DROP;
                  drop_hdr_d = 1'b1;
               end else begin
                  state_d    = S_HDR;
                  drop_hdr_d = 1'b0;
               end
            end else begin
               grant_d = {NUM_SRC{1'b0}};
            end
         end
         S_HDR: begin
            src_ready    = grant_q & {NUM_SRC{!busy}};
            datain       = cur_byte_s;
            packet_valid = 1'b1;
            if (xfer_s) begin
               cnt_d   = cur_byte_s[7:2];
               state_d = (cur_byte_s[7:2] == 6'd0) ? S_PARITY : S_PAYLOAD;
            end else begin
               state_d = S_HDR;
            end
         end
         S_PAYLOAD: begin
            src_ready    = grant_q & {NUM_SRC{!busy}};
            datain       = cur_byte_s;
            packet_valid = 1'b1;
            if (xfer_s) begin
               cnt_d   = cnt_q - 6'd1;
               state_d = (cnt_q == 6'd1) ? S_PARITY : S_PAYLOAD;
            end else begin
               state_d = S_PAYLOAD;
            end
         end
         S_PARITY: begin
            src_ready = grant_q & {NUM_SRC{!busy}};
            datain    = cur_byte_s;
            if (xfer_s) begin
               pkt_done     = 1'b1;
               last_grant_d = rr_idx_from_grant(grant_q);
               grant_d      = {NUM_SRC{1'b0}};
               state_d      = S_IDLE;
            end else begin
               state_d = S_PARITY;
            end
         end
         S_DROP: begin
            // Draining ignores router back-pressure: the router never sees these bytes.
            src_ready = grant_q;
            if (cur_valid_s) begin
               if (drop_hdr_q) begin
                  drop_hdr_d = 1'b0;
               end else if (cnt_q == 6'd0) begin
                  hdr_err      = 1'b1;
                  last_grant_d = rr_idx_from_grant(grant_q);
                  grant_d      = {NUM_SRC{1'b0}};
                  state_d      = S_IDLE;
               end else begin
                  cnt_d = cnt_q - 6'd1;
               end
            end else begin
               state_d = S_DROP;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = {NUM_SRC{1'b0}};
         end
      endcase
      if (state_q != S_IDLE && !cur_valid_s) begin
         proto_err_d = 1'b1;
      end else begin
         proto_err_d = proto_err_d;
      end
   end

   // Encode a one-hot grant back to a source index.
   function automatic logic [IW-1:0] rr_idx_from_grant(input logic [NUM_SRC-1:0] oh);
      logic [IW-1:0] idx;
      idx = {IW{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         idx = idx | (IW'(i) & {IW{oh[i]}});
      end
      return idx;
   endfunction

   // State registers with synchronous reset; a reset mid-packet abandons it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 6'd0;
         last_grant_q <= IW'(NUM_SRC - 1);
         grant_q      <= {NUM_SRC{1'b0}};
         drop_hdr_q   <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         drop_hdr_q   <= drop_hdr_d;
         proto_err_q  <= proto_err_d;
      end
   end

   assign grant     = grant_q;
   assign proto_err = proto_err_q;

endmodule

// File: doc/router_src_arbiter.md
# router_src_arbiter

Input-side scheduler for the 1x3 router. Up to NUM_SRC packet sources share the router's single byte-wide input (`datain`, `packet_valid`, `busy`). The block grants the input round-robin, one whole packet at a time, and walks each packet through header, payload and parity using the length in the header. It honours router back-pressure and discards packets addressed to the nonexistent port 3.

## Interface
- NUM_SRC, 3: number of requesting sources, 2..8.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- src_valid  in  NUM_SRC  source i presents a byte on its slice of src_data.
- src_data  in  8*NUM_SRC  byte of source i at [8i+7:8i].
- src_ready  out  NUM_SRC  byte of source i accepted on this edge when src_valid[i] is also high.
- busy  in  1  router cannot take a byte this cycle.
- datain  out  8  byte to router.
- packet_valid  out  1  high for header and payload bytes, low for the parity byte and when idle.
- grant  out  NUM_SRC  one-hot granted source; 0 in IDLE.
- pkt_done  out  1  one-cycle pulse on the parity-byte transfer.
- hdr_err  out  1  one-cycle pulse when a dest=2'b11 packet finishes draining.
- proto_err  out  1  sticky; set on a source gap mid-packet, cleared only by reset.

## Operation
- Packet format: header {len[7:2], dest[1:0]}, then len payload bytes (0..63), then 1 parity byte. Parity is passed through unchecked.
- State IDLE:
  - Round-robin search of src_valid, starting at last_grant+1 mod NUM_SRC. After reset, last_grant = NUM_SRC-1, so source 0 has priority.
  - On a hit, latch grant g and the header of source g.
  - dest != 2'b11: go to HDR. dest == 2'b11: go to DROP.
  - No transfer happens in IDLE. This forces at least one idle cycle between packets.
- Transfer rule: in HDR, PAYLOAD and PARITY, src_ready[g] = !busy and all other src_ready bits are 0. A byte moves on every edge where src_valid[g] && !busy.
- HDR: datain = src_data[g], packet_valid = 1. On transfer, load the 6-bit counter cnt = len. Go to PARITY if len == 0, else to PAYLOAD.
- PAYLOAD: datain = src_data[g], packet_valid = 1. On each transfer, cnt decrements. A transfer with cnt == 1 goes to PARITY.
- PARITY: datain = src_data[g], packet_valid = 0. On transfer, pulse pkt_done, set last_grant = g, go to IDLE.
- DROP:
  - src_ready[g] = 1 regardless of busy; packet_valid = 0; datain = 8'h00.
  - Consume the header, len payload bytes and the parity byte (len+2 bytes), counting down the same counter.
  - On the last byte, pulse hdr_err, set last_grant = g, go to IDLE.
- Gap: src_valid[g] low in HDR, PAYLOAD, PARITY or DROP sets proto_err. The counter only advances on transfers. datain is src_data[g] unqualified.
- Grant never changes mid-packet, even if higher-priority sources assert src_valid.

## Timing
- Reset (synchronous, highest priority, including mid-packet):
  - state = IDLE, cnt = 0, last_grant = NUM_SRC-1.
  - grant = 0, packet_valid = 0, datain = 8'h00, src_ready = 0, pkt_done = 0, hdr_err = 0, proto_err = 0.
  - A packet partly delivered is abandoned. The router is reset by the same system reset.
- datain, packet_valid and src_ready are combinational from registered state, src_data and busy. There is no added latency: a byte accepted from a source is the byte the router takes on the same edge.
- Latency: src_valid rises in IDLE at cycle 0 -> header on datain in cycle 1. The minimum packet occupancy is len+2 transfer cycles plus 1 IDLE cycle.
- busy held high: datain, packet_valid, cnt and state frozen; src_ready = 0. DROP is unaffected.
- A source that asserts src_valid while another is granted waits. Its src_ready stays 0.
- cnt is 6 bits. len = 63 needs no wrap handling. len = 0 skips PAYLOAD.

## Test plan
- Reset: assert reset 2 cycles mid-PAYLOAD -> next cycle all outputs 0 and state IDLE. A following packet from source 2 starts with its header, then a later packet from source 0 wins over source 2.
- Single packet: source 1 sends header 8'h21 (len 8, dest 01), 8 payload bytes, parity; busy = 0 -> grant = 3'b010 for 10 cycles. packet_valid is high 9 cycles, then low on the parity byte. pkt_done pulses once and datain matches the source bytes in order.
- Round robin: all 3 sources hold len-2 packets ready after reset -> packet order 0,1,2,0. Exactly one IDLE cycle separates packets.
- Back-pressure: busy high 3 cycles after payload byte 4 of a len-8 packet -> datain is held at byte 5 and src_ready = 0 for those cycles. The total count is still 8 payload bytes and parity follows correctly.
- Drop: source 0 header 8'h17 (len 5, dest 11) -> 7 bytes consumed in 7 cycles with busy = 1 throughout. packet_valid stays 0, hdr_err pulses on the 7th, and grant then passes to source 1.
- Zero length and gap: header 8'h02 -> header then parity, no PAYLOAD cycle. Drop src_valid for 1 cycle mid-payload -> proto_err sets and stays set until reset.
